trigger_chain_sat_monitor: RTL and testbench
============================================

// Module: trigger_chain_sat_monitor
// PURPOSE
//  Downstream consumer of the 8-channel trigger chain output (8 ch x 8 samples x 5 bits per aclk).
//  Over a programmed window, counts per channel the samples at full-scale code (0 or 2^NBITS-1).
//  Used to check AGC/filter output levels. Results are latched at window end and read back by channel select.
//  Single clock domain (aclk).
// PARAMETERS
//  NCHAN      8   channels
//  NSAMP      8   samples per channel per clock
//  NBITS      5   bits per sample (unsigned code)
//  CNT_WIDTH  24  per-channel count width
// PORTS
//  aclk         in   1                  clock; all logic on rising edge
//  reset_i      in   1                  synchronous, active-high reset
//  start_i      in   1                  request a window; sampled only in IDLE
//  window_i     in   24                 window length W in aclk cycles; latched on start
//  dat_i        in   [NCHAN][NSAMP*NBITS] chain output, sample s of ch c = dat_i[c][NBITS*s +: NBITS]
//  sel_i        in   $clog2(NCHAN)      channel select for readback
//  busy_o       out  1                  window or pipeline flush in progress
//  done_o       out  1                  one-cycle pulse: results latched
//  sat_count_o  out  CNT_WIDTH          latched count for channel sel_i
//  ovf_o        out  NCHAN              latched per-channel counter-saturated flags
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0, sat_count_o=0, ovf_o=0; accumulators, held results and pipeline cleared.
//  Reset mid-window: same as above. No done_o. Prior held results are lost.
//  FSM states: IDLE -> RUN -> FLUSH -> IDLE.
//   IDLE: start_i=1 and window_i!=0 at edge e0 -> latch W and clear accumulators/ovf -> RUN; busy_o=1 after e0.
//     start_i with window_i==0 is ignored (stay IDLE, busy_o=0).
//   RUN: dat_i is sampled at edges e1..eW exactly (W samples per lane); dat_i outside this range is ignored.
//     Cycle counter reaches W -> FLUSH.
//   FLUSH: 2 cycles to drain the pipeline -> IDLE.
//   start_i outside IDLE is ignored (no queueing).
//  Pipeline (per channel):
//   stage1 at e(k): flag[s] = (sample==0) | (sample=={NBITS{1}}).
//   stage2 at e(k+1): popcount of flags, 0..NSAMP, registered.
//   stage3 at e(k+2): accumulate.
//  Accumulate rule: acc = min(acc + pop, 2^CNT_WIDTH-1).
//   If the unclamped sum exceeds the max, the channel's ovf bit is set and stays set for the window.
//  Latch: at e(W+3) held[c]<=acc[c], ovf_o<=ovf; done_o=1 for exactly the cycle after e(W+3); busy_o=0 from the same edge.
//   done_o therefore rises W+3 edges after the start edge.
//   A new start_i is accepted in the done_o cycle.
//  Held results persist until the next window's latch or reset.
//  Readback: sat_count_o <= held[sel_i] registered, 1-cycle latency from sel_i change.
//   sel_i >= NCHAN returns 0.
// TESTING
//  1. All lanes code 31, W=4, start at e0 -> done_o high after e7; every channel reads 32; ovf_o=0.
//  2. ch3 lanes 0,7 = 0, all else 16, W=10 -> ch3=20, others 0; sel 3->0 changes sat_count_o one cycle later.
//  3. Full-scale data only at e0 and e(W+1), mid-scale (16) otherwise, W=5 -> all counts 0.
//  4. start_i held high through RUN -> single window, done_o once. start with window_i=0 -> busy_o stays 0.
//  5. W=100, reset_i at e3 -> outputs 0, no done_o; fresh start W=2 with all-31 data -> counts 16.
//  6. CNT_WIDTH=4, W=3, all lanes 0 -> counts clamp at 15, ovf_o=8'hFF; next window with mid-scale data -> ovf_o=0.

Source files
------------

// File: rtl/trigger_chain_sat_monitor.sv
// Windowed per-channel count of full-scale samples (code 0 or all-ones) on the trigger chain output.
// Results are latched at window end and read back one channel at a time.
module trigger_chain_sat_monitor #(
    parameter int unsigned NCHAN     = 8,
    parameter int unsigned NSAMP     = 8,
    parameter int unsigned NBITS     = 5,
    parameter int unsigned CNT_WIDTH = 24
) (
    input  logic                                aclk,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic [23:0]                         window_i,
    input  logic [NCHAN-1:0][NSAMP*NBITS-1:0]   dat_i,
    input  logic [$clog2(NCHAN)-1:0]            sel_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [CNT_WIDTH-1:0]                sat_count_o,
    output logic [NCHAN-1:0]                    ovf_o
);

    localparam int unsigned WIN_W = 24;
    localparam int unsigned POP_W = $clog2(NSAMP + 1);
    localparam int unsigned SUM_W = CNT_WIDTH + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                                state_q;
    logic [WIN_W-1:0]                      win_q;
    logic [WIN_W-1:0]                      cnt_q;
    logic [1:0]                            flush_q;
    logic [NCHAN-1:0][NSAMP-1:0]           flag_q;
    logic [NCHAN-1:0][NSAMP-1:0]           flag_c;
    logic [NCHAN-1:0][POP_W-1:0]           pop_q;
    logic [NCHAN-1:0][POP_W-1:0]           pop_c;
    logic [NCHAN-1:0][CNT_WIDTH-1:0]       acc_q;
    logic [NCHAN-1:0][SUM_W-1:0]           sum_c;
    logic [NCHAN-1:0]                      ovf_acc_q;
    logic [NCHAN-1:0][CNT_WIDTH-1:0]       held_q;

    // Full-scale detect on raw samples, popcount on registered flags, unclamped running sum.
    always_comb begin
        flag_c = '0;
        pop_c  = '0;
        sum_c  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            for (int s = 0; s < NSAMP; s++) begin
                flag_c[c][s] = (dat_i[c][NBITS*s +: NBITS] == '0) ||
                               (dat_i[c][NBITS*s +: NBITS] == {NBITS{1'b1}});
                pop_c[c]     = pop_c[c] + POP_W'(flag_q[c][s]);
            end
            sum_c[c] = {1'b0, acc_q[c]} + SUM_W'(pop_q[c]);
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            win_q       <= '0;
            cnt_q       <= '0;
            flush_q     <= '0;
            flag_q      <= '0;
            pop_q       <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= '0;
            held_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sat_count_o <= '0;
            ovf_o       <= '0;
        end else begin
            done_o <= 1'b0;
            // Only samples taken in RUN enter the pipeline; zeros elsewhere add nothing.
            flag_q <= (state_q == RUN) ? flag_c : '0;
            pop_q  <= pop_c;

            for (int c = 0; c < NCHAN; c++) begin
                if (sum_c[c] > SUM_MAX) begin
                    acc_q[c]     <= {CNT_WIDTH{1'b1}};
                    ovf_acc_q[c] <= 1'b1;
                end else begin
                    acc_q[c] <= sum_c[c][CNT_WIDTH-1:0];
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_i && (window_i != '0)) begin
                        win_q     <= window_i;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        ovf_acc_q <= '0;
                        busy_o    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + WIN_W'(1);
                    if ((cnt_q + WIN_W'(1)) == win_q) begin
                        flush_q <= '0;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Last sample reaches the accumulator two edges after the window ends.
                    if (flush_q == 2'd2) begin
                        held_q  <= acc_q;
                        ovf_o   <= ovf_acc_q;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        flush_q <= flush_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (32'(sel_i) < NCHAN) begin
                sat_count_o <= held_q[sel_i];
            end else begin
                sat_count_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_trigger_chain_sat_monitor.sv
// Scoreboarded bench for trigger_chain_sat_monitor: a 24-bit counter instance and a 4-bit one
// driven in parallel so clamping and overflow can be exercised with short windows.
module tb_trigger_chain_sat_monitor;

    localparam int unsigned NCHAN = 8;
    localparam int unsigned NSAMP = 8;
    localparam int unsigned NBITS = 5;

    typedef logic [NCHAN-1:0][NSAMP*NBITS-1:0] dat_t;
    typedef struct packed {
        logic [NCHAN-1:0][23:0] cnt;
        logic [NCHAN-1:0]       ovf;
        logic [NCHAN-1:0][3:0]  cnt_s;
        logic [NCHAN-1:0]       ovf_s;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] window = '0;
    dat_t        dat = '0;
    logic [2:0]  sel = '0;
    logic        busy, done, busy_s, done_s;
    logic [23:0] sat_count;
    logic [3:0]  sat_count_s;
    logic [7:0]  ovf, ovf_s;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    trigger_chain_sat_monitor dut (
        .aclk(clk), .reset_i(reset), .start_i(start), .window_i(window), .dat_i(dat),
        .sel_i(sel), .busy_o(busy), .done_o(done), .sat_count_o(sat_count), .ovf_o(ovf)
    );

    trigger_chain_sat_monitor #(.CNT_WIDTH(4)) dut_s (
        .aclk(clk), .reset_i(reset), .start_i(start), .window_i(window), .dat_i(dat),
        .sel_i(sel), .busy_o(busy_s), .done_o(done_s), .sat_count_o(sat_count_s), .ovf_o(ovf_s)
    );

    always @(posedge clk) if (done) done_seen <= done_seen + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Stimulus pattern for edge index k of a window of length w.
    function automatic dat_t gen(input int mode, input int k, input int w);
        dat_t d;
        logic [4:0] code;
        d = '0;
        for (int c = 0; c < NCHAN; c++) begin
            for (int s = 0; s < NSAMP; s++) begin
                case (mode)
                    0: code = 5'd31;
                    1: code = (c == 3 && (s == 0 || s == 7)) ? 5'd0 : 5'd16;
                    2: code = (k == 0 || k == w + 1) ? 5'd31 : 5'd16;
                    3: code = 5'd0;
                    default: code = 5'd16;
                endcase
                d[c][NBITS*s +: NBITS] = code;
            end
        end
        return d;
    endfunction

    // Reference: count full-scale samples over edges e1..ew, then clamp per counter width.
    function automatic exp_t model(input int mode, input int w);
        exp_t e;
        dat_t d;
        int   tot;
        logic [4:0] code;
        e = '0;
        for (int c = 0; c < NCHAN; c++) begin
            tot = 0;
            for (int k = 1; k <= w; k++) begin
                d = gen(mode, k, w);
                for (int s = 0; s < NSAMP; s++) begin
                    code = d[c][NBITS*s +: NBITS];
                    if (code == 5'd0 || code == 5'd31) tot++;
                end
            end
            e.cnt[c]   = 24'(tot);
            e.ovf[c]   = 1'b0;
            e.cnt_s[c] = (tot > 15) ? 4'd15 : 4'(tot);
            e.ovf_s[c] = (tot > 15);
        end
        return e;
    endfunction

    task automatic run_window(input int mode, input int w, input bit hold_start, input string name);
        exp_t e;
        int   d0;
        exp_q.push_back(model(mode, w));
        d0 = done_seen;
        for (int k = 0; k <= w + 3; k++) begin
            @(negedge clk);
            if (k == 1)     check_eq({name, "_busy_run"}, 32'(busy), 32'd1);
            if (k == w + 3) check_eq({name, "_done_early"}, 32'(done), 32'd0);
            start  = (k == 0) || hold_start;
            window = 24'(w);
            dat    = gen(mode, k, w);
        end
        @(negedge clk);
        start = 1'b0;
        check_eq({name, "_done"}, 32'(done), 32'd1);
        check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check_eq({name, "_sb_empty"}, 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_eq({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
        check_eq({name, "_ovf_s"}, 32'(ovf_s), 32'(e.ovf_s));
        @(negedge clk);
        check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check_eq({name, "_done_count"}, 32'(done_seen - d0), 32'd1);
        check_eq({name, "_busy_idle"}, 32'(busy), 32'd0);
        for (int c = 0; c < NCHAN; c++) begin
            sel = 3'(c);
            @(negedge clk);
            check_eq($sformatf("%s_cnt%0d", name, c), 32'(sat_count), 32'(e.cnt[c]));
            check_eq($sformatf("%s_cnts%0d", name, c), 32'(sat_count_s), 32'(e.cnt_s[c]));
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cnt", 32'(sat_count), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_window(0, 4, 1'b0, "t1");
        run_window(1, 10, 1'b0, "t2");
        sel = 3'd3;
        @(negedge clk);
        check_eq("t2_sel3", 32'(sat_count), 32'd20);
        sel = 3'd0;
        #1;
        check_eq("t2_sel_hold", 32'(sat_count), 32'd20);
        @(negedge clk);
        check_eq("t2_sel0", 32'(sat_count), 32'd0);

        run_window(2, 5, 1'b0, "t3");
        run_window(0, 3, 1'b1, "t4");

        // Zero-length window request must be ignored.
        d0 = done_seen;
        start  = 1'b1;
        window = '0;
        @(negedge clk);
        start = 1'b0;
        check_eq("t4_zero_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("t4_zero_busy2", 32'(busy), 32'd0);
        check_eq("t4_zero_done", 32'(done_seen - d0), 32'd0);

        // Reset in the middle of a long window.
        d0 = done_seen;
        sel = 3'd2;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            start  = (k == 0);
            window = 24'd100;
            dat    = gen(0, k, 100);
            reset  = (k == 3);
        end
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_cnt", 32'(sat_count), 32'd0);
        check_eq("t5_ovf", 32'(ovf), 32'd0);
        repeat (110) @(negedge clk);
        check_eq("t5_no_done", 32'(done_seen - d0), 32'd0);
        check_eq("t5_held_lost", 32'(sat_count), 32'd0);
        run_window(0, 2, 1'b0, "t5b");

        run_window(3, 3, 1'b0, "t6");
        run_window(4, 3, 1'b0, "t6b");

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
